// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave register interface.
package spi_pkg;

  localparam int ADDR_W         = 7;
  localparam int DATA_W         = 8;
  localparam int FRAME_BITS_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sig_sync.sv
// Multi-flop synchronizer for an asynchronous input, with rise/fall detection
// computed from the synchronized value.
module sig_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  // Shift the raw input through the synchronizer chain.
  always_comb begin
    sync_d[0] = d_i;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[STAGES-1];
  end

  // Synchronizer and edge-history flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: decodes rw/addr/data frames into register-access strobes
// and serializes read data back on miso, all in the clk domain.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_dv,
  output logic              rw_out,
  output logic [DATA_W-1:0] rx_d,
  output logic              rxdv,
  input  logic [DATA_W-1:0] tx_d
);

  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int FLUSH_W    = $clog2(SYNC_STAGES + 2);
  localparam int FLUSH_LAST = SYNC_STAGES + 1;

  logic sclk_lvl_unused;
  logic sclk_rise_s, sclk_fall_s;
  logic cs_s, cs_rise_s, cs_fall_s;
  logic mosi_s;
  logic [1:0] mosi_edges_unused;
  logic start_s;
  logic [DATA_W-1:0] byte_s;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] txsh_q, txsh_d;
  logic              tx_loaded_q, tx_loaded_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] rx_byte_q, rx_byte_d;
  logic              addr_dv_q, addr_dv_d;
  logic              rxdv_q, rxdv_d;
  logic              oe_q, oe_d;
  logic              miso_q, miso_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic              armed_q, armed_d;

  sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .d_i(sclk),
    .q_o(sclk_lvl_unused), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
  );

  sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .d_i(cs_n),
    .q_o(cs_s), .rise_o(cs_rise_s), .fall_o(cs_fall_s)
  );

  sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .d_i(mosi),
    .q_o(mosi_s), .rise_o(mosi_edges_unused[0]), .fall_o(mosi_edges_unused[1])
  );

  assign byte_s  = {shift_q[DATA_W-2:0], mosi_s};
  assign start_s = cs_fall_s & armed_q;

  // The reset value of the cs_n synchronizer would fake a falling edge if
  // cs_n is already low at reset release; only arm once cs_n is seen high.
  always_comb begin
    if (flush_q != FLUSH_W'(FLUSH_LAST)) begin
      flush_d = flush_q + FLUSH_W'(1);
    end else begin
      flush_d = flush_q;
    end
    if (!armed_q && (flush_q == FLUSH_W'(FLUSH_LAST)) && cs_s) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
  end

  // Frame FSM: next state, shift registers and output strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    txsh_d      = txsh_q;
    tx_loaded_d = tx_loaded_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    rx_byte_d   = rx_byte_q;
    oe_d        = oe_q;
    addr_dv_d   = 1'b0;
    rxdv_d      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_s) begin
          state_d     = ST_ADDR;
          cnt_d       = {CNT_W{1'b0}};
          shift_d     = {DATA_W{1'b0}};
          txsh_d      = {DATA_W{1'b0}};
          tx_loaded_d = 1'b0;
          oe_d        = 1'b0;
        end else if (cs_rise_s) begin
          state_d = ST_IDLE;
          txsh_d  = {DATA_W{1'b0}};
          oe_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_ADDR: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end else if (sclk_rise_s) begin
          shift_d = byte_s;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_W)) begin
            state_d   = ST_DATA;
            rw_d      = byte_s[DATA_W-1];
            addr_d    = byte_s[ADDR_W-1:0];
            addr_dv_d = 1'b1;
            oe_d      = byte_s[DATA_W-1];
          end else begin
            state_d = ST_ADDR;
          end
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
          txsh_d  = {DATA_W{1'b0}};
          oe_d    = 1'b0;
        end else if (sclk_rise_s) begin
          shift_d = byte_s;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            state_d = ST_DONE;
            if (!rw_q) begin
              rx_byte_d = byte_s;
              rxdv_d    = 1'b1;
            end else begin
              rx_byte_d = rx_byte_q;
            end
          end else begin
            state_d = ST_DATA;
          end
        end else if (sclk_fall_s && rw_q) begin
          // First fall after the address byte loads tx_d; later falls shift.
          if (!tx_loaded_q) begin
            txsh_d      = tx_d;
            tx_loaded_d = 1'b1;
          end else begin
            txsh_d = {txsh_q[DATA_W-2:0], 1'b0};
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
        oe_d    = 1'b0;
      end
    endcase
    miso_d = oe_d & txsh_d[DATA_W-1];
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      shift_q     <= {DATA_W{1'b0}};
      txsh_q      <= {DATA_W{1'b0}};
      tx_loaded_q <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      rw_q        <= 1'b0;
      rx_byte_q   <= {DATA_W{1'b0}};
      addr_dv_q   <= 1'b0;
      rxdv_q      <= 1'b0;
      oe_q        <= 1'b0;
      miso_q      <= 1'b0;
      flush_q     <= {FLUSH_W{1'b0}};
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      txsh_q      <= txsh_d;
      tx_loaded_q <= tx_loaded_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      rx_byte_q   <= rx_byte_d;
      addr_dv_q   <= addr_dv_d;
      rxdv_q      <= rxdv_d;
      oe_q        <= oe_d;
      miso_q      <= miso_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
    end
  end

  assign miso    = miso_q;
  assign miso_oe = oe_q;
  assign addr    = addr_q;
  assign addr_dv = addr_dv_q;
  assign rw_out  = rw_q;
  assign rx_d    = rx_byte_q;
  assign rxdv    = rxdv_q;

endmodule
